// File: rtl/mode_ctrl_p_if.sv
// -----------------------------------------------------------------------------
// mode_ctrl_p_if
// Bundles the operand, mode and status signals of mode_ctrl_p.
//   x      : data operand (W bits), driven by the master
//   on     : mode select 0 off / 1 enumerate / 2 count / 3 update
//   start  : run/arm request
//   y      : data register (W bits), driven by the controller
//   s      : step counter register (SW bits)
//   b      : 1 when s == 0
//   regime : current mode 0 idle / 1 enumerate / 2 count / 3 update
//   active : high while the enumerate phase is running
//   busy   : high whenever the controller is not idle
// Modports: master (stimulus side), slave (mode_ctrl_p).
// -----------------------------------------------------------------------------
interface mode_ctrl_p_if #(
   parameter int W  = 8,
   parameter int SW = 3
);
   logic [W-1:0]  x;
   logic [1:0]    on;
   logic          start;
   logic [W-1:0]  y;
   logic [SW-1:0] s;
   logic          b;
   logic [1:0]    regime;
   logic          active;
   logic          busy;

   modport master (
      output x, on, start,
      input  y, s, b, regime, active, busy
   );

   modport slave (
      input  x, on, start,
      output y, s, b, regime, active, busy
   );
endinterface

// File: rtl/mode_ctrl_p.sv
// -----------------------------------------------------------------------------
// mode_ctrl_p
// Mode controller with four regimes: idle, enumerate, count and update.
// The mode input is only sampled for dispatch while idle; each regime then
// runs its own short sequence over the data register y and step counter s.
//
// Ports:
//   clk  : single clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : mode_ctrl_p_if.slave (x, on, start in; y, s, b, regime, active,
//          busy out)
//
// Parameters: W (data width), SW (step counter width), ENUM_LEN (number of
// enumerate active cycles, 1..255).
//
// Optional feature: define MODE_CTRL_P_ABORT_EN to let on=0 force any
// non-idle state back to IDLE (y and s held). Without it, on is ignored
// outside IDLE.
// -----------------------------------------------------------------------------
module mode_ctrl_p #(
   parameter int W        = 8,
   parameter int SW       = 3,
   parameter int ENUM_LEN = 6
) (
   input  logic         clk,
   input  logic         rst,
   mode_ctrl_p_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      UPD_LOAD,
      UPD_STEP,
      UPD_DONE,
      CNT,
      ENUM_WAIT,
      ENUM_RUN
   } state_t;

   localparam logic [7:0]    ENUM_LOAD = 8'(ENUM_LEN - 1);
   localparam logic [SW-1:0] S_ONE     = SW'(1);
   localparam logic [SW-1:0] S_TWO     = SW'(2);

   state_t        state_q, state_d;
   logic [W-1:0]  y_q, y_d;
   logic [SW-1:0] s_q, s_d;
   logic [7:0]    cnt_q, cnt_d;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         y_q     <= '0;
         s_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         s_q     <= s_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and register update logic
   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      s_d     = s_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         IDLE: begin
            unique case (bus.on)
               2'd1: begin
                  if (bus.start) begin
                     state_d = ENUM_RUN;
                     s_d     = '0;
                     cnt_d   = ENUM_LOAD;
                  end else begin
                     state_d = ENUM_WAIT;
                  end
               end
               2'd2: begin
                  // Count is only armed with start; y captures x on entry.
                  if (bus.start) begin
                     state_d = CNT;
                     y_d     = bus.x;
                  end
               end
               2'd3:    state_d = UPD_LOAD;
               default: state_d = IDLE;
            endcase
         end

         UPD_LOAD: begin
            y_d     = bus.x;
            state_d = UPD_STEP;
         end

         UPD_STEP: begin
            y_d     = {y_q[W-2:0], y_q[W-1]};
            s_d     = s_q - S_ONE;
            state_d = UPD_DONE;
         end

         UPD_DONE: state_d = IDLE;

         CNT: begin
            if (bus.start) begin
               // Reload y as s passes through zero (s wraps to all ones).
               if (s_q == '0) y_d = bus.x;
               s_d = s_q - S_ONE;
            end else begin
               state_d = IDLE;
            end
         end

         ENUM_WAIT: begin
            if (bus.start) begin
               state_d = ENUM_RUN;
               s_d     = '0;
               cnt_d   = ENUM_LOAD;
            end
         end

         ENUM_RUN: begin
            s_d = s_q + S_TWO;
            // Counter was loaded with ENUM_LEN-1, so leaving on zero gives
            // exactly ENUM_LEN active cycles; it parks at zero afterwards.
            if (cnt_q == 8'd0) state_d = IDLE;
            else               cnt_d   = cnt_q - 8'd1;
         end

         default: state_d = IDLE;
      endcase

`ifdef MODE_CTRL_P_ABORT_EN
      if (state_q != IDLE && bus.on == 2'd0) begin
         state_d = IDLE;
         y_d     = y_q;
         s_d     = s_q;
         cnt_d   = cnt_q;
      end
`endif
   end

   // Output decode from the state register
   always_comb begin
      bus.regime = 2'd0;
      bus.active = 1'b0;
      bus.busy   = (state_q != IDLE);
      unique case (state_q)
         UPD_LOAD, UPD_STEP, UPD_DONE: bus.regime = 2'd3;
         CNT:                          bus.regime = 2'd2;
         ENUM_WAIT:                    bus.regime = 2'd1;
         ENUM_RUN: begin
            bus.regime = 2'd1;
            bus.active = 1'b1;
         end
         default:                      bus.regime = 2'd0;
      endcase
   end

   assign bus.y = y_q;
   assign bus.s = s_q;
   assign bus.b = (s_q == '0);

endmodule
